// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory and hands each returned word plus its PC to decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h8002_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        enable_decode
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc_reg, pc_reg_n;
  logic [31:0] hold_data, out_data_n;
  logic        discard, discard_n;
  logic        deliver, buf_load, en_n;
  logic        accept, slot_free;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc_reg;
  assign accept    = imem_req && imem_ready;
  // Decode frees the slot this edge either because it is empty or being taken.
  assign slot_free = !enable_decode || !stall;

  always_comb begin
    state_n    = state;
    pc_reg_n   = pc_reg;
    discard_n  = discard;
    deliver    = 1'b0;
    buf_load   = 1'b0;
    out_data_n = hold_data;
    case (state)
      IDLE: if (fetch_enable) state_n = REQ;
      REQ: begin
        if (accept)             state_n = WAIT;
        else if (!fetch_enable) state_n = IDLE;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = REQ;
          end else if (slot_free) begin
            deliver    = 1'b1;
            out_data_n = imem_resp_data;
            state_n    = REQ;
          end else begin
            buf_load = 1'b1;
            state_n  = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          deliver = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    if (deliver) pc_reg_n = pc_reg + PC_STEP;
    en_n = deliver || (enable_decode && stall);

    // Redirect overrides everything but reset; any read still in flight is
    // marked for discard so its data never reaches decode.
    if (redirect_valid) begin
      pc_reg_n = {redirect_pc[31:2], 2'b00};
      deliver  = 1'b0;
      buf_load = 1'b0;
      en_n     = 1'b0;
      case (state)
        IDLE: state_n = IDLE;
        REQ: begin
          if (accept) begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_n   = REQ;
            discard_n = 1'b0;
          end else begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end
        end
        HOLD:    state_n = REQ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      pc_reg        <= PC_RESET;
      discard       <= 1'b0;
      hold_data     <= 32'd0;
      insn          <= 32'd0;
      pc            <= 32'd0;
      enable_decode <= 1'b0;
    end else begin
      state         <= state_n;
      pc_reg        <= pc_reg_n;
      discard       <= discard_n;
      enable_decode <= en_n;
      if (buf_load) hold_data <= imem_resp_data;
      if (deliver) begin
        insn <= out_data_n;
        pc   <= pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for the basic/stall flow, then
// hand sequences for redirect, wrap and reset-in-flight corners.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, fetch_enable, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_resp_valid;
  logic [31:0] imem_addr, imem_resp_data;
  logic [31:0] insn, pc;
  logic        enable_decode;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_enable(fetch_enable), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .insn(insn), .pc(pc), .enable_decode(enable_decode)
  );

  always #5 clock = ~clock;

  // Memory responder: data = addr ^ 0x1234, fixed latency `lat` (>=1) cycles
  // after accept. Deliberately not cleared by reset so a stale response can
  // arrive after the DUT resets.
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
  end
  always @(posedge clock) begin
    if (imem_req && imem_ready) begin
      if (lat <= 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= imem_addr ^ 32'h1234;
        cnt             <= 0;
      end else begin
        imem_resp_valid <= 1'b0;
        pend_addr       <= imem_addr;
        cnt             <= lat - 1;
      end
    end else if (cnt != 0) begin
      imem_resp_valid <= (cnt == 1);
      imem_resp_data  <= pend_addr ^ 32'h1234;
      cnt             <= cnt - 1;
    end else begin
      imem_resp_valid <= 1'b0;
    end
  end

  // Log every instruction decode actually takes.
  logic [31:0] dq_pc[$];
  logic [31:0] dq_insn[$];
  always @(negedge clock) begin
    if (!reset && enable_decode && !stall) begin
      dq_pc.push_back(pc);
      dq_insn.push_back(insn);
    end
  end

  typedef struct {
    logic        rst, fe, stl, rdy;
    logic        req;
    logic [31:0] addr;
    logic        en;
    logic [31:0] pc, insn;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for imem_req got 0 expected 1", name);
    end
  endtask

  task automatic wait_deliv(input string name, input int num);
    int n = 0;
    while (dq_pc.size() < num && n < 60) begin
      tick();
      n++;
    end
    // let the negedge monitor see the final cycle
    @(negedge clock);
    #1;
    if (dq_pc.size() < num) begin
      checks++;
      errors++;
      $display("FAIL %s: deliveries got %0d expected %0d", name, dq_pc.size(), num);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_ready = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_ready = 1'b1;

    //         rst fe stl rdy  req addr          en pc            insn
    vecs[0]  = '{1, 0, 0, 1,   0, 32'h80020000, 0, 32'h00000000, 32'h00000000};
    vecs[1]  = '{0, 1, 0, 1,   1, 32'h80020000, 0, 32'h00000000, 32'h00000000};
    vecs[2]  = '{0, 1, 0, 1,   0, 32'h80020000, 0, 32'h00000000, 32'h00000000};
    vecs[3]  = '{0, 1, 0, 1,   1, 32'h80020004, 1, 32'h80020000, 32'h80021234};
    vecs[4]  = '{0, 1, 0, 1,   0, 32'h80020004, 0, 32'h80020000, 32'h80021234};
    vecs[5]  = '{0, 1, 0, 1,   1, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[6]  = '{0, 1, 1, 1,   0, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[7]  = '{0, 1, 1, 1,   0, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[8]  = '{0, 1, 1, 1,   0, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[9]  = '{0, 1, 1, 1,   0, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[10] = '{0, 1, 1, 1,   0, 32'h80020008, 1, 32'h80020004, 32'h80021230};
    vecs[11] = '{0, 1, 0, 1,   1, 32'h8002000C, 1, 32'h80020008, 32'h8002123C};
    vecs[12] = '{0, 0, 0, 1,   0, 32'h8002000C, 0, 32'h80020008, 32'h8002123C};
    vecs[13] = '{0, 0, 0, 1,   1, 32'h80020010, 1, 32'h8002000C, 32'h80021238};
    vecs[14] = '{0, 0, 0, 0,   0, 32'h80020010, 0, 32'h8002000C, 32'h80021238};
    vecs[15] = '{0, 0, 0, 0,   0, 32'h80020010, 0, 32'h8002000C, 32'h80021238};

    // Cycle-by-cycle: reset, zero-wait fetch, 5-cycle stall with HOLD, drop to IDLE.
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst; fetch_enable = vecs[i].fe;
      stall = vecs[i].stl; imem_ready = vecs[i].rdy;
      tick();
      checks++;
      if (imem_req !== vecs[i].req || imem_addr !== vecs[i].addr ||
          enable_decode !== vecs[i].en || pc !== vecs[i].pc || insn !== vecs[i].insn) begin
        errors++;
        $display("FAIL vec%0d: got req=%b addr=%08h en=%b pc=%08h insn=%08h expected req=%b addr=%08h en=%b pc=%08h insn=%08h",
                 i, imem_req, imem_addr, enable_decode, pc, insn,
                 vecs[i].req, vecs[i].addr, vecs[i].en, vecs[i].pc, vecs[i].insn);
      end
    end

    // Redirect during a 3-cycle WAIT: late response dropped.
    do_reset();
    lat = 3; fetch_enable = 1'b1;
    dq_pc.delete(); dq_insn.delete();
    wait_req("rd_wait_req0");
    tick();                                  // accept
    redirect_valid = 1'b1; redirect_pc = 32'h80030013;
    tick();
    redirect_valid = 1'b0;
    check("rd_wait_addr", imem_addr, 32'h80030010);
    check("rd_wait_req", {31'd0, imem_req}, 32'd0);
    wait_req("rd_wait_req1");
    check("rd_wait_reqaddr", imem_addr, 32'h80030010);
    wait_deliv("rd_wait_deliv", 1);
    if (dq_pc.size() >= 1) begin
      check("rd_wait_pc", dq_pc[0], 32'h80030010);
      check("rd_wait_insn", dq_insn[0], 32'h80031224);
    end

    // Reset while in WAIT; stale response arrives right after.
    lat = 2;
    wait_req("rst_req0");
    tick();                                  // accept, response due in 2
    reset = 1'b1;
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h80020000);
    check("rst_en", {31'd0, enable_decode}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_insn", insn, 32'd0);
    reset = 1'b0;
    dq_pc.delete(); dq_insn.delete();
    tick();                                  // stale resp_valid high this edge
    check("rst_stale_en", {31'd0, enable_decode}, 32'd0);
    check("rst_restart_addr", imem_addr, 32'h80020000);
    wait_deliv("rst_deliv", 1);
    if (dq_pc.size() >= 1) begin
      check("rst_pc0", dq_pc[0], 32'h80020000);
      check("rst_insn0", dq_insn[0], 32'h80021234);
    end

    // Redirect coinciding with a response, then with a request accept.
    do_reset();
    lat = 1; fetch_enable = 1'b1;
    dq_pc.delete(); dq_insn.delete();
    wait_req("rd2_req0");
    tick();                                  // accept 80020000
    redirect_valid = 1'b1; redirect_pc = 32'h80040000;
    tick();                                  // response + redirect
    check("rd2_addrA", imem_addr, 32'h80040000);
    check("rd2_reqA", {31'd0, imem_req}, 32'd1);
    redirect_pc = 32'h80050000;
    tick();                                  // accept + redirect
    redirect_valid = 1'b0;
    check("rd2_addrB", imem_addr, 32'h80050000);
    wait_deliv("rd2_deliv", 2);
    if (dq_pc.size() >= 2) begin
      check("rd2_pc0", dq_pc[0], 32'h80050000);
      check("rd2_insn0", dq_insn[0], 32'h80051234);
      check("rd2_pc1", dq_pc[1], 32'h80050004);
      check("rd2_insn1", dq_insn[1], 32'h80051230);
    end

    // PC wrap at the top of the address space.
    do_reset();
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_idle_req", {31'd0, imem_req}, 32'd0);
    check("wrap_addr", imem_addr, 32'hFFFFFFFC);
    dq_pc.delete(); dq_insn.delete();
    fetch_enable = 1'b1;
    wait_deliv("wrap_deliv", 2);
    if (dq_pc.size() >= 2) begin
      check("wrap_pc0", dq_pc[0], 32'hFFFFFFFC);
      check("wrap_insn0", dq_insn[0], 32'hFFFFEDC8);
      check("wrap_pc1", dq_pc[1], 32'h00000000);
      check("wrap_insn1", dq_insn[1], 32'h00001234);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
